alu_issue_stage: RTL

Operand-fetch and writeback stage that sits directly upstream of the 16-bit combinational ALU. It accepts register-addressed instructions over a valid/ready handshake and reads operands from an internal 8×16 register file. It drives the ALU's opcode, operand and shift inputs from a pipeline register, then presents and commits the ALU result and carry back to the register file. Back-to-back dependent instructions issue at full rate via a result bypass.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_regfile.sv | 44 ++++
 rtl/alu_issue_stage.sv | 133 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int AW    = $clog2(NREGS);

  // ALU opcode encodings; values 8..15 are not decoded by the issue stage.
  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] SLT = 4'd4;
  localparam logic [3:0] SGT = 4'd5;
  localparam logic [3:0] SNE = 4'd6;
  localparam logic [3:0] MAX = 4'd7;

  typedef logic [AW-1:0] reg_addr_t;

  // Contents of the EX pipeline register; its fields drive the ALU directly.
  typedef struct packed {
    logic             valid;
    logic [3:0]       opcode;
    reg_addr_t        rd;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [4:0]       shamt;
  } ex_stage_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file: NREGS x WIDTH, two combinational read ports, one write port, r0 reads 0.
// Latency: reads combinational; a write at edge t is visible in the following cycle.
// Backpressure: none; the write enable is qualified by the caller.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (clears all entries)
//   i_raddr1/o_rdata1 read port 1
//   i_raddr2/o_rdata2 read port 2
//   i_we/i_waddr/i_wdata write port; writes to address 0 are dropped
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREGS = alu_pkg::NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    i_raddr1,
  output logic [WIDTH-1:0] o_rdata1,
  input  logic [AW-1:0]    i_raddr2,
  output logic [WIDTH-1:0] o_rdata2,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata
);

  logic [WIDTH-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // r0 is forced to zero on read as well, so it never depends on storage.
  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand fetch + writeback around an external combinational ALU, with result bypass.
// Latency: accept at edge t, ALU inputs valid t..t+1, commit at edge t+1; one instr/cycle.
// Backpressure: in_ready = !ex_valid || out_ready; a stalled EX holds all outputs stable.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   in_valid/in_ready          instruction handshake; in_opcode/in_rd/in_rs1/in_rs2/in_shamt
//   alu_opcode/input1/input2/shiftValue   driven from the EX register
//   alu_result/alu_carryFlag   combinational ALU response
//   out_valid/out_ready        writeback handshake; out_rd/out_result/out_carry
//   carry_sticky               OR of committed carries since reset
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int NREGS = alu_pkg::NREGS,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_opcode,
  input  logic [AW-1:0]    in_rd,
  input  logic [AW-1:0]    in_rs1,
  input  logic [AW-1:0]    in_rs2,
  input  logic [4:0]       in_shamt,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_input1,
  output logic [WIDTH-1:0] alu_input2,
  output logic [4:0]       alu_shiftValue,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carryFlag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW-1:0]    out_rd,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             carry_sticky
);

  ex_stage_t        r_ex;
  logic             r_carry_sticky;

  logic             w_accept;
  logic             w_commit;
  logic             w_rf_we;
  logic [WIDTH-1:0] w_rf_rdata1;
  logic [WIDTH-1:0] w_rf_rdata2;
  logic [WIDTH-1:0] w_op1;
  logic [WIDTH-1:0] w_op2;

  assign in_ready = !r_ex.valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_commit = r_ex.valid && out_ready;
  assign w_rf_we  = w_commit && (r_ex.rd != '0);

  alu_regfile #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_raddr1 (in_rs1),
    .o_rdata1 (w_rf_rdata1),
    .i_raddr2 (in_rs2),
    .o_rdata2 (w_rf_rdata2),
    .i_we     (w_rf_we),
    .i_waddr  (r_ex.rd),
    .i_wdata  (alu_result)
  );

  // Bypass: the instruction in EX commits at the same edge the new one is
  // accepted, so its result is the architecturally current value of ex_rd.
  always_comb begin
    w_op1 = '0;
    if (in_rs1 != '0) begin
      if (r_ex.valid && (r_ex.rd != '0) && (in_rs1 == r_ex.rd)) begin
        w_op1 = alu_result;
      end else begin
        w_op1 = w_rf_rdata1;
      end
    end
  end

  always_comb begin
    w_op2 = '0;
    if (in_rs2 != '0) begin
      if (r_ex.valid && (r_ex.rd != '0) && (in_rs2 == r_ex.rd)) begin
        w_op2 = alu_result;
      end else begin
        w_op2 = w_rf_rdata2;
      end
    end
  end

  // Only valid is cleared on commit; the other fields hold their last values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex <= '0;
    end else if (w_accept) begin
      r_ex.valid  <= 1'b1;
      r_ex.opcode <= in_opcode;
      r_ex.rd     <= in_rd;
      r_ex.op1    <= w_op1;
      r_ex.op2    <= w_op2;
      r_ex.shamt  <= in_shamt;
    end else if (w_commit) begin
      r_ex.valid  <= 1'b0;
    end
  end

  // Commits to r0 still contribute their carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_carry_sticky <= 1'b0;
    end else if (w_commit) begin
      r_carry_sticky <= r_carry_sticky | alu_carryFlag;
    end
  end

  assign alu_opcode     = r_ex.opcode;
  assign alu_input1     = r_ex.op1;
  assign alu_input2     = r_ex.op2;
  assign alu_shiftValue = r_ex.shamt;

  assign out_valid    = r_ex.valid;
  assign out_rd       = r_ex.rd;
  assign out_result   = alu_result;
  assign out_carry    = alu_carryFlag;
  assign carry_sticky = r_carry_sticky;

endmodule
